// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared definitions for the register-file write-back path.
// Holds the register-memory write patterns, the write-back requester
// encoding, and the fixed index/data widths.
package rf_ctrl_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned PAT_W     = 3;

  // Write patterns understood by the register memory; it performs the
  // byte extension itself, so load patterns pass through untouched.
  localparam logic [PAT_W-1:0] REG_WRITE_WORD          = 3'd0;
  localparam logic [PAT_W-1:0] REG_WRITE_BYTE_SIGNED   = 3'd1;
  localparam logic [PAT_W-1:0] REG_WRITE_BYTE_UNSIGNED = 3'd2;

  typedef enum logic {
    REQ_ALU  = 1'b0,
    REQ_LOAD = 1'b1
  } req_e;

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: pending-load vector for the 32 architectural registers.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   issue_valid/rd   load issue request; a transfer marks issue_rd pending
//   issue_ready      no load outstanding to issue_rd, none in the stage
//   stg_load_hit     write stage currently holds a load to issue_rd
//   clr_en, clr_idx  load write-back transfer clearing clr_idx
//   rs1, rs2         queried source indices
//   pend1, pend2     pending state of rs1 / rs2
module rf_scoreboard
  import rf_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  output logic                 issue_ready,
  input  logic                 stg_load_hit,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  output logic                 pend1,
  output logic                 pend2
);

  logic [XLEN-1:0] pending;
  logic [XLEN-1:0] pending_next;

  assign issue_ready = ~pending[issue_rd] & ~stg_load_hit;
  assign pend1       = pending[rs1];
  assign pend2       = pending[rs2];

  // Clear first, then set, so a same-cycle issue to the register being
  // written back leaves it pending. x0 can never be pending.
  always_comb begin
    pending_next = pending;
    if (clr_en) pending_next[clr_idx] = 1'b0;
    if (issue_valid && issue_ready) pending_next[issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_next;
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: shares the register memory's single write port
// between the ALU and the load unit (round-robin), driving it from a
// one-entry registered stage, and tracks outstanding load destinations.
// Optional feature macro: RF_SCOREBOARD_EN (load scoreboard and hazard
// logic; when undefined issue_ready is tied high and busy reflects only
// the in-flight write).
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   alu_valid/ready, alu_rd/data    ALU write-back handshake (word writes)
//   ld_valid/ready, ld_rd/data/pattern  load write-back handshake
//   issue_valid/ready, issue_rd     load issue handshake
//   rs1, rs2 -> rs1_busy, rs2_busy  combinational hazard query
//   rf_wr_*                         registered register-memory write port
module regfile_wb_scheduler
  import rf_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [REG_IDX_W-1:0] ld_rd,
  input  logic [XLEN-1:0]      ld_data,
  input  logic [PAT_W-1:0]     ld_pattern,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 rf_wr_enable,
  output logic [REG_IDX_W-1:0] rf_wr_address,
  output logic [XLEN-1:0]      rf_wr_data,
  output logic [PAT_W-1:0]     rf_write_pattern
);

  req_e                 last;
  logic                 alu_xfer;
  logic                 ld_xfer;
  logic                 stg_valid;
  logic                 stg_is_load;
  logic [REG_IDX_W-1:0] stg_addr;
  logic [XLEN-1:0]      stg_data;
  logic [PAT_W-1:0]     stg_pat;
  logic                 stg_hit1;
  logic                 stg_hit2;

  // On a tie the requester that did not win most recently goes first.
  always_comb begin
    alu_ready = alu_valid & (~ld_valid | (last == REQ_LOAD));
    ld_ready  = ld_valid  & (~alu_valid | (last == REQ_ALU));
  end

  assign alu_xfer = alu_valid & alu_ready;
  assign ld_xfer  = ld_valid & ld_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last        <= REQ_LOAD;
      stg_valid   <= 1'b0;
      stg_is_load <= 1'b0;
      stg_addr    <= '0;
      stg_data    <= '0;
      stg_pat     <= '0;
    end else begin
      stg_valid <= alu_xfer | ld_xfer;
      if (alu_xfer) begin
        last        <= REQ_ALU;
        stg_is_load <= 1'b0;
        stg_addr    <= alu_rd;
        stg_data    <= alu_data;
        stg_pat     <= REG_WRITE_WORD;
      end else if (ld_xfer) begin
        last        <= REQ_LOAD;
        stg_is_load <= 1'b1;
        stg_addr    <= ld_rd;
        stg_data    <= ld_data;
        stg_pat     <= ld_pattern;
      end
    end
  end

  // Writes to x0 are accepted but never reach the register memory.
  assign rf_wr_enable     = stg_valid & (stg_addr != '0);
  assign rf_wr_address    = stg_addr;
  assign rf_wr_data       = stg_data;
  assign rf_write_pattern = stg_pat;

  assign stg_hit1 = rf_wr_enable & (stg_addr == rs1);
  assign stg_hit2 = rf_wr_enable & (stg_addr == rs2);

`ifdef RF_SCOREBOARD_EN
  logic pend1;
  logic pend2;

  rf_scoreboard u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_ready  (issue_ready),
    .stg_load_hit (stg_valid & stg_is_load & (stg_addr == issue_rd)),
    .clr_en       (ld_xfer),
    .clr_idx      (ld_rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .pend1        (pend1),
    .pend2        (pend2)
  );

  assign rs1_busy = pend1 | stg_hit1;
  assign rs2_busy = pend2 | stg_hit2;
`else
  logic unused_sb;

  assign unused_sb   = ^{issue_valid, issue_rd, stg_is_load};
  assign issue_ready = 1'b1;
  assign rs1_busy    = stg_hit1;
  assign rs2_busy    = stg_hit2;
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios plus random traffic,
// checked against a behavioural model; register-memory writes are
// scoreboarded through a queue drained by an independent monitor.
module tb_regfile_wb_scheduler;
  import rf_ctrl_pkg::*;

`ifdef RF_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0, alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        ld_valid = 1'b0, ld_ready;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic [2:0]  ld_pattern = '0;
  logic        issue_valid = 1'b0, issue_ready;
  logic [4:0]  issue_rd = '0;
  logic [4:0]  rs1 = '0, rs2 = '0;
  logic        rs1_busy, rs2_busy;
  logic        rf_wr_enable;
  logic [4:0]  rf_wr_address;
  logic [31:0] rf_wr_data;
  logic [2:0]  rf_write_pattern;

  regfile_wb_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_pattern(ld_pattern),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_wr_enable(rf_wr_enable), .rf_wr_address(rf_wr_address),
    .rf_wr_data(rf_wr_data), .rf_write_pattern(rf_write_pattern)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  pat;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  // Reference model state: registers awaiting a load, who won last,
  // and the write accepted on the previous edge (still in flight).
  bit         m_pend[32];
  bit         m_last_was_load;
  bit         inf_v, inf_load;
  logic [4:0] inf_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_last_was_load = 1'b1;
    inf_v = 1'b0; inf_load = 1'b0; inf_rd = '0;
    exp_q.delete();
  endtask

  function automatic bit m_busy(input logic [4:0] r);
    return (SB && m_pend[r]) || (inf_v && inf_rd == r && r != 5'd0);
  endfunction

  // Monitor: every cycle the port must show exactly what the previous
  // edge's transfer (if any) predicted.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check("wr_en", rf_wr_enable, w.en);
        if (w.en) begin
          check("wr_addr", rf_wr_address, w.rd);
          check("wr_data", rf_wr_data, w.data);
          check("wr_pattern", rf_write_pattern, w.pat);
        end
      end else begin
        check("wr_idle", rf_wr_enable, 0);
      end
    end
  end

  task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ldd,
                      input logic [2:0] lp, input bit iv, input logic [4:0] ird,
                      input logic [4:0] r1, input logic [4:0] r2);
    bit e_alu, e_ld, e_iss;
    wr_t w;
    @(negedge clk);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid = lv; ld_rd = lrd; ld_data = ldd; ld_pattern = lp;
    issue_valid = iv; issue_rd = ird; rs1 = r1; rs2 = r2;
    #1;
    e_alu = av && (!lv || m_last_was_load);
    e_ld  = lv && (!av || !m_last_was_load);
    e_iss = SB ? !(m_pend[ird] || (inf_v && inf_load && inf_rd == ird)) : 1'b1;
    check("alu_ready", alu_ready, e_alu);
    check("ld_ready", ld_ready, e_ld);
    check("issue_ready", issue_ready, e_iss);
    check("rs1_busy", rs1_busy, m_busy(r1));
    check("rs2_busy", rs2_busy, m_busy(r2));
    @(posedge clk);
    if (e_alu) begin
      w.en = (ard != 0); w.rd = ard; w.data = ad; w.pat = REG_WRITE_WORD;
      exp_q.push_back(w);
      m_last_was_load = 1'b0;
      inf_v = 1'b1; inf_load = 1'b0; inf_rd = ard;
    end else if (e_ld) begin
      w.en = (lrd != 0); w.rd = lrd; w.data = ldd; w.pat = lp;
      exp_q.push_back(w);
      m_last_was_load = 1'b1;
      inf_v = 1'b1; inf_load = 1'b1; inf_rd = lrd;
    end else begin
      inf_v = 1'b0;
    end
    if (e_ld) m_pend[lrd] = 1'b0;
    if (iv && e_iss && ird != 0) m_pend[ird] = 1'b1;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_wr_en", rf_wr_enable, 0);
    check("rst_wr_addr", rf_wr_address, 0);
    check("rst_wr_data", rf_wr_data, 0);
    check("rst_wr_pattern", rf_write_pattern, 0);
    check("rst_alu_ready", alu_ready, 0);
    check("rst_rs1_busy", rs1_busy, 0);
    #1 rst_n = 1'b1;

    // ALU word write after reset
    step(1, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 5, 0);
    idle(5, 0);

    // contention: both valid four cycles
    for (int unsigned i = 0; i < 4; i++)
      step(1, 5'(i + 1), $urandom, 1, 5'(i + 10), $urandom, REG_WRITE_BYTE_SIGNED, 0, 0, 0, 0);
    idle(0, 0);

    // hazard on x7 across issue, re-issue and write-back
    step(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    idle(7, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    step(0, 0, 0, 1, 7, 32'hCAFE_0001, REG_WRITE_BYTE_UNSIGNED, 1, 7, 7, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    idle(7, 0);
    idle(7, 0);

    // x0: write dropped, never pending
    step(0, 0, 0, 1, 0, 32'hFFFF_FFFF, REG_WRITE_WORD, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(0, 0);

    // same-cycle issue and write-back to x9: set wins
    step(0, 0, 0, 1, 9, 32'h0000_0099, REG_WRITE_WORD, 1, 9, 9, 0);
    idle(9, 0);
    idle(9, 0);
    step(0, 0, 0, 1, 9, 32'h0000_0999, REG_WRITE_WORD, 0, 0, 9, 0);
    idle(9, 0);
    idle(9, 0);

    // reset mid-flight: pending x3, ALU write to x4 in the stage
    step(1, 4, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 3, 3, 4);
    @(negedge clk);
    alu_valid = 0; issue_valid = 0; rs1 = 3; rs2 = 4;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_wr_en", rf_wr_enable, 0);
    check("midrst_rs1_busy", rs1_busy, 0);
    check("midrst_rs2_busy", rs2_busy, 0);
    #1 rst_n = 1'b1;
    idle(3, 4);
    idle(3, 4);

    // random traffic
    for (int unsigned i = 0; i < 3000; i++)
      step($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom, 3'($urandom),
           $urandom_range(0, 1), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    idle(0, 0);
    idle(0, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
